// File: rtl/seq_tx_101101.sv
// seq_tx_101101: frames a parallel payload as a serial bit stream.
// Each frame is the sync word (MSB first), then the payload (MSB first),
// then an optional even-parity bit.
// Bits advance only on bit_en strobes. abort or rst_n drop the frame in flight.
//
// state   | meaning
// --------+--------------------------------------------------
// ST_IDLE | line held at 0, waiting for a payload handshake
// ST_SYNC | shifting out the sync word, cnt_q = bit index
// ST_DATA | shifting out the payload MSB first, cnt_q = bits left - 1
// ST_PAR  | sending the even-parity bit of the latched payload
module seq_tx_101101 #(
  parameter int                SYNC_W    = 6,
  parameter logic [SYNC_W-1:0] SYNC      = 6'b101101,
  parameter int                DATA_W    = 8,
  parameter bit                PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              bit_en,
  input  logic              abort,
  output logic              tx_out,
  output logic              tx_active,
  output logic              frame_done
);

  localparam int CNT_MAX = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_PAR  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic              par_q, par_d;
  logic              frame_done_q, frame_done_d;
  logic [SYNC_W-1:0] sync_sh;

  // The parity bit is computed once at acceptance, because the shift
  // register no longer holds the whole payload by the time it is sent.

  assign in_ready   = (state_q == ST_IDLE) && !abort;
  assign tx_active  = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign sync_sh    = SYNC >> cnt_q;

  // Serial output selected from the registered state only.
  always_comb begin
    tx_out = 1'b0;
    case (state_q)
      ST_IDLE: tx_out = 1'b0;
      ST_SYNC: tx_out = sync_sh[0];
      ST_DATA: tx_out = sr_q[DATA_W-1];
      ST_PAR:  tx_out = par_q;
      default: tx_out = 1'b0;
    endcase
  end

  // Next-state and datapath update. abort overrides bit_en and the handshake.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    par_d        = par_q;
    frame_done_d = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sr_d    = in_data;
            par_d   = ^in_data;
            state_d = ST_SYNC;
            cnt_d   = SYNC_LAST;
          end
        end
        ST_SYNC: begin
          if (bit_en) begin
            if (cnt_q == '0) begin
              state_d = ST_DATA;
              cnt_d   = DATA_LAST;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (bit_en) begin
            sr_d = sr_q << 1;
            if (cnt_q == '0) begin
              if (PARITY_EN) begin
                state_d = ST_PAR;
              end else begin
                state_d      = ST_IDLE;
                frame_done_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        ST_PAR: begin
          if (bit_en) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter, payload and done-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sr_q         <= '0;
      par_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      par_q        <= par_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_seq_tx_101101.sv
// Bench for seq_tx_101101: the stimulus pushes the expected serial bits
// and the expected done pulses; the monitors pop and compare them.
module tb_seq_tx_101101;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_valid2, bit_en, abort;
  logic [7:0] in_data, in_data2;
  logic       in_ready, tx_out, tx_active, frame_done;
  logic       in_ready2, tx_out2, tx_active2, frame_done2;

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];
  logic exp2_q[$];
  int   done_pending  = 0;
  int   done2_pending = 0;
  logic prev1 = 1'b0;
  logic prev2 = 1'b0;
  logic e1, e2;

  always #5 clk = ~clk;

  seq_tx_101101 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .bit_en(bit_en), .abort(abort), .tx_out(tx_out),
    .tx_active(tx_active), .frame_done(frame_done)
  );

  seq_tx_101101 #(.PARITY_EN(1'b0)) dut_np (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .bit_en(bit_en), .abort(1'b0), .tx_out(tx_out2),
    .tx_active(tx_active2), .frame_done(frame_done2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the parity-enabled instance.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, !tx_active && !abort);
      if (tx_active) begin
        chk("bit_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e1 = exp_q.pop_front();
          chk("tx_out", tx_out, e1);
        end
      end else begin
        chk("tx_idle_zero", tx_out, 0);
      end
      if (frame_done) begin
        chk("done_follows_frame", prev1, 1);
        chk("done_expected", done_pending > 0, 1);
        if (done_pending > 0) done_pending--;
      end
      prev1 = tx_active;
    end else begin
      prev1 = 1'b0;
    end
  end

  // Monitor for the parity-disabled instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_active2) begin
        chk("np_bit_expected", exp2_q.size() > 0, 1);
        if (exp2_q.size() > 0) begin
          e2 = exp2_q.pop_front();
          chk("np_tx_out", tx_out2, e2);
        end
      end else begin
        chk("np_tx_idle_zero", tx_out2, 0);
      end
      if (frame_done2) begin
        chk("np_done_follows_frame", prev2, 1);
        chk("np_done_expected", done2_pending > 0, 1);
        if (done2_pending > 0) done2_pending--;
      end
      prev2 = tx_active2;
    end else begin
      prev2 = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input logic [14:0] bits, input int n, input int p, input bit which);
    for (int i = n - 1; i >= 0; i--)
      for (int k = 0; k < p; k++)
        if (which) exp2_q.push_back(bits[i]);
        else       exp_q.push_back(bits[i]);
  endtask

  task automatic accept(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = ~d;
  endtask

  task automatic run_bits(input int n, input int p);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < p; k++) begin
        bit_en = (k == p - 1);
        step();
      end
    bit_en = 1'b1;
  endtask

  task automatic settle(input string name);
    repeat (3) step();
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_done_seen"}, done_pending, 0);
    chk({name, "_np_drained"}, exp2_q.size(), 0);
    chk({name, "_np_done_seen"}, done2_pending, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    in_data = 8'h00; in_data2 = 8'h00; bit_en = 1'b1; abort = 1'b0;
    #12;
    chk("rst_tx_out", tx_out, 0);
    chk("rst_tx_active", tx_active, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_frame_done", frame_done, 0);
    step();
    rst_n = 1'b1;
    step();

    // A5, bit_en always on: 101101 10100101 0
    push_bits(15'b101101101001010, 15, 1, 0);
    done_pending++;
    accept(8'hA5);
    run_bits(15, 1);
    settle("a5");

    // 07, bit_en every third cycle: 101101 00000111 1, each bit held 3 cycles
    push_bits(15'b101101000001111, 15, 3, 0);
    done_pending++;
    accept(8'h07);
    run_bits(15, 3);
    settle("07_slow");

    // in_valid held: 00 frame, one idle cycle, then FF frame
    push_bits(15'b101101000000000, 15, 1, 0);
    push_bits(15'b101101111111110, 15, 1, 0);
    done_pending += 2;
    in_valid = 1'b1;
    in_data  = 8'h00;
    step();
    in_data = 8'hFF;
    repeat (15) step();
    chk("gap_tx_active", tx_active, 0);
    chk("gap_in_ready", in_ready, 1);
    chk("gap_tx_out", tx_out, 0);
    step();
    chk("second_frame_started", tx_active, 1);
    in_valid = 1'b0;
    repeat (14) step();
    settle("b2b");

    // abort during the third payload bit of C3
    push_bits(15'b000000101101110, 9, 1, 0);
    accept(8'hC3);
    run_bits(8, 1);
    abort = 1'b1;
    #1;
    chk("abort_blocks_ready", in_ready, 0);
    step();
    abort = 1'b0;
    #1;
    chk("abort_tx_active", tx_active, 0);
    chk("abort_tx_out", tx_out, 0);
    chk("abort_in_ready", in_ready, 1);
    settle("abort");

    // reset pulsed between edges during sync
    push_bits(15'b000000000000101, 3, 1, 0);
    accept(8'hA5);
    run_bits(3, 1);
    chk("pre_reset_tx_out", tx_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx_out", tx_out, 0);
    chk("async_rst_tx_active", tx_active, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_frame_done", frame_done, 0);
    step();
    rst_n = 1'b1;
    push_bits(15'b101101001111000, 15, 1, 0);
    done_pending++;
    accept(8'h3C);
    chk("post_reset_first_bit", tx_out, 1);
    run_bits(15, 1);
    settle("reset");

    // no-parity build, 81: 101101 10000001
    push_bits(15'b010110110000001, 14, 1, 1);
    done2_pending++;
    in_valid2 = 1'b1;
    in_data2  = 8'h81;
    step();
    in_valid2 = 1'b0;
    in_data2  = 8'h00;
    repeat (14) step();
    settle("noparity");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_tx_101101.md
SEQ_TX_101101 -- requirements
Module: seq_tx_101101

Interface
REQ-001 Parameter SYNC_W, default 6, sync word width in bits.
REQ-002 Parameter SYNC, default 6'b101101, sync word, transmitted MSB first.
REQ-003 Parameter DATA_W, default 8, payload width in bits.
REQ-004 Parameter PARITY_EN, default 1, 1 = append even-parity bit after payload.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  payload offered on in_data.
REQ-008 in_data  input  DATA_W  payload word.
REQ-009 in_ready  output  1  block can accept a payload this cycle.
REQ-010 bit_en  input  1  bit-period strobe; the current serial bit is consumed in each cycle where it is 1.
REQ-011 abort  input  1  synchronous frame cancel.
REQ-012 tx_out  output  1  serial bit stream.
REQ-013 tx_active  output  1  frame in progress.
REQ-014 frame_done  output  1  one-cycle pulse after the last bit of a frame is consumed.

Function
REQ-015 States SHALL be IDLE, SYNC, DATA, PAR; tx_active = 1 in every state except IDLE.
REQ-016 in_ready SHALL be 1 exactly when state is IDLE and abort is 0 (combinational from state and abort).
REQ-017 Handshake: in_valid && in_ready at edge t latches in_data into a shift register; state = SYNC and bit counter = SYNC_W-1 from cycle t+1.
REQ-018 in_valid while in_ready = 0 SHALL be ignored; nothing is queued.
REQ-019 tx_out (combinational from registered state): IDLE -> 0; SYNC -> SYNC[bit counter]; DATA -> shift register MSB; PAR -> XOR of all latched payload bits.
REQ-020 Each bit SHALL remain on tx_out until the first cycle with bit_en = 1 in its state, then advance at that edge; bit_en in IDLE is ignored.
REQ-021 SYNC with bit_en: counter 0 -> DATA, counter = DATA_W-1; otherwise counter decrements.
REQ-022 DATA with bit_en: shift register shifts left one bit; counter 0 -> PAR if PARITY_EN = 1, else IDLE; otherwise counter decrements.
REQ-023 PAR with bit_en -> IDLE.
REQ-024 frame_done SHALL be registered: 1 for exactly the one cycle after the edge on which the final bit (parity, or last payload bit when PARITY_EN = 0) is consumed; 0 otherwise.
REQ-025 Frame length SHALL be SYNC_W + DATA_W + PARITY_EN bit periods; with bit_en held 1, defaults give 15 consecutive cycles of frame bits.
REQ-026 abort = 1 in any state SHALL force IDLE at the next edge, clear the counter, and suppress frame_done; abort has priority over bit_en and over a handshake in the same cycle.
REQ-027 Back-to-back: after a frame ends, at least one IDLE cycle (tx_out = 0, in_ready = 1) SHALL precede the next frame; a held in_valid is accepted in that cycle.
REQ-028 Payload change on in_data after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-029 rst_n = 0 SHALL asynchronously force state IDLE, counter 0, shift register 0, frame_done 0; hence tx_out = 0, tx_active = 0, in_ready = 1 while rst_n = 0 (abort = 0).
REQ-030 Reset asserted mid-frame SHALL discard the frame with no frame_done; first handshake is possible on the first edge after rst_n deasserts.

Verification
REQ-031 bit_en = 1 constant, in_data = 8'hA5 accepted -> tx_out = 1,0,1,1,0,1, 1,0,1,0,0,1,0,1, 0 over 15 cycles; frame_done = 1 in the following cycle; tx_active = 1 for exactly 15 cycles.
REQ-032 in_data = 8'h07, bit_en every 3rd cycle -> each of the 15 bits held 3 cycles; parity bit = 1; frame_done single-cycle pulse.
REQ-033 in_valid = 1 constant with payloads 8'h00 and 8'hFF -> frames separated by exactly one IDLE cycle; second frame = 101101 11111111 0; in_valid during the first frame is not accepted.
REQ-034 abort = 1 during the 3rd payload bit -> IDLE next cycle, tx_out = 0, no frame_done, in_ready = 1 one cycle later.
REQ-035 rst_n pulsed low mid-sync between edges -> outputs reset immediately (not on the next edge); a new frame after release starts with sync bit 1.
REQ-036 PARITY_EN = 0 build, in_data = 8'h81 -> 14-bit frame 101101 10000001; frame_done follows the last payload bit.
